aes_encrypt_iter: RTL and testbench

AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

---
 rtl/aes_pkg.sv | 38 +++
 rtl/aes_encrypt_iter_if.sv | 23 ++
 rtl/MixColumns.sv | 24 ++
 rtl/SBytes.sv | 15 +
 rtl/aes_encrypt_iter.sv | 108 ++++++++++
 tb/tb_aes_encrypt_iter.sv | 305 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, FSM state encoding, S-box table
// and the GF(2^8) xtime helper used by MixColumns.
package aes_pkg;

    localparam int NROUNDS = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_t;

    // FIPS-197 forward S-box, indexed by the input byte.
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_encrypt_iter_if.sv
// Plaintext-in / ciphertext-out handshake plus the round-key lookup bus.
// The master side owns the key store and both producer/consumer ends.
interface aes_encrypt_iter_if;
    logic         inValid;
    logic         inReady;
    logic [127:0] plainIn;
    logic [3:0]   roundNumber;
    logic [127:0] roundKey;
    logic         outValid;
    logic         outReady;
    logic [127:0] cipherOut;
    logic         busy;

    modport master (
        output inValid, plainIn, roundKey, outReady,
        input  inReady, roundNumber, outValid, cipherOut, busy
    );

    modport slave (
        input  inValid, plainIn, roundKey, outReady,
        output inReady, roundNumber, outValid, cipherOut, busy
    );
endinterface

// File: rtl/MixColumns.sv
// Combinational AES MixColumns over a full 128-bit state (4 columns).
module MixColumns
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;

        assign a0 = din[127-32*c -: 8];
        assign a1 = din[119-32*c -: 8];
        assign a2 = din[111-32*c -: 8];
        assign a3 = din[103-32*c -: 8];

        // Fixed matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2], 3*a = xtime(a)^a.
        assign dout[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign dout[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign dout[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign dout[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/SBytes.sv
// Byte-wise S-box substitution over NWords 32-bit words.
module SBytes
    import aes_pkg::*;
#(
    parameter int NWords = 4
) (
    input  logic [32*NWords-1:0] din,
    output logic [32*NWords-1:0] dout
);

    for (genvar i = 0; i < 4*NWords; i++) begin : g_byte
        assign dout[8*i +: 8] = SBOX[din[8*i +: 8]];
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one full round per clock on a single 128-bit
// state register. Round keys come from an external store addressed by
// roundNumber and are expected in the same cycle.
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int NROUNDS = aes_pkg::NROUNDS
) (
    input logic               clk,
    input logic               rst,
    aes_encrypt_iter_if.slave bus
);

    aes_state_t   state_q, state_d;
    logic [127:0] st_q;
    logic [127:0] cipher_q;
    logic [3:0]   rnd_q;

    logic [127:0] sb, sr, mc, round_out;
    logic         last;
    logic         accept;
    logic         release_blk;

    // Row r of the column-major state rotates left by r bytes.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    SBytes #(.NWords(4)) u_sbytes (
        .din  (st_q),
        .dout (sb)
    );

    assign sr = shift_rows(sb);

    MixColumns u_mix (
        .din  (sr),
        .dout (mc)
    );

    // The final round skips MixColumns.
    assign last      = (rnd_q == 4'(NROUNDS));
    assign round_out = (last ? sr : mc) ^ bus.roundKey;

    assign accept      = (state_q == ST_IDLE) && bus.inValid;
    assign release_blk = (state_q == ST_DONE) && bus.outReady;

    assign bus.roundNumber = rnd_q;
    assign bus.cipherOut   = cipher_q;

    // Next-state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        bus.inReady  = 1'b0;
        bus.outValid = 1'b0;
        bus.busy     = 1'b1;
        case (state_q)
            ST_IDLE: begin
                bus.inReady = 1'b1;
                bus.busy    = 1'b0;
                if (bus.inValid) state_d = ST_ROUND;
            end
            ST_ROUND: begin
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                bus.outValid = 1'b1;
                if (bus.outReady) state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                bus.busy = 1'b0;
            end
        endcase
    end

    // FSM state register; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Datapath: initial AddRoundKey on accept, one round per cycle after,
    // ciphertext captured only on the final round so a reset never exposes
    // a partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= '0;
            cipher_q <= '0;
            rnd_q    <= '0;
        end else if (accept) begin
            st_q  <= bus.plainIn ^ bus.roundKey;
            rnd_q <= 4'd1;
        end else if (state_q == ST_ROUND) begin
            st_q <= round_out;
            if (last) cipher_q <= round_out;
            else      rnd_q    <= rnd_q + 4'd1;
        end else if (release_blk) begin
            rnd_q <= '0;
        end
    end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: FIPS-197 known answers plus
// random blocks checked against a byte-level reference model whose S-box is
// derived from the GF(2^8) inverse and affine map.
module tb_aes_encrypt_iter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [7:0]   sbox_m [0:255];
    logic [127:0] rk [0:15];

    aes_encrypt_iter_if bus ();

    aes_encrypt_iter #(.NROUNDS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key store: round key for the requested index, same cycle.
    always_comb bus.roundKey = rk[bus.roundNumber];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        d = d << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [127:0] k;
        logic [127:0] o;
        k = round_key(key, 0);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            k = round_key(key, r);
            for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[4*c+w] = s[4*((c+w)%4)+w];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c+0] = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int w = 0; w < 4; w++) s[4*c+w] = t[4*c+w];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic load_keys(input logic [127:0] key);
        for (int r = 0; r < 16; r++) rk[r] = (r <= 10) ? round_key(key, r) : '0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offer a block and step through the accept edge.
    task automatic accept(input logic [127:0] pt, input bit keep_valid);
        int n;
        n = 0;
        bus.inValid = 1'b1;
        bus.plainIn = pt;
        while (!bus.inReady && n < 30) begin
            step();
            n++;
        end
        chk("accept_ready", bus.inReady, 1);
        chk("rn_idle", bus.roundNumber, 0);
        step();
        if (!keep_valid) bus.inValid = 1'b0;
        chk("busy_after_accept", bus.busy, 1);
    endtask

    // Run rounds until outValid, checking round index and latency.
    task automatic finish_rounds(input bit noise);
        int lat;
        bit seq_ok;
        lat = 0;
        seq_ok = 1'b1;
        while (!bus.outValid && lat < 30) begin
            if (bus.roundNumber != 4'(lat + 1) || bus.inReady) seq_ok = 1'b0;
            if (noise) begin
                bus.inValid  = 1'($urandom_range(0, 1));
                bus.plainIn  = rand128();
                bus.outReady = 1'($urandom_range(0, 1));
            end
            step();
            lat++;
        end
        bus.outReady = 1'b0;
        chk("round_seq", seq_ok, 1);
        chk("latency", lat, 10);
        chk("rn_done", bus.roundNumber, 10);
    endtask

    // Check result, hold it under backpressure, then hand it off.
    task automatic drain(input logic [127:0] exp, input int hold);
        logic [127:0] held;
        bit stable;
        held = bus.cipherOut;
        stable = 1'b1;
        chk("cipher", bus.cipherOut, exp);
        for (int i = 0; i < hold; i++) begin
            step();
            if (!bus.outValid || bus.cipherOut !== held || bus.roundNumber != 4'd10) stable = 1'b0;
        end
        chk("hold_stable", stable, 1);
        bus.outReady = 1'b1;
        step();
        bus.outReady = 1'b0;
        chk("post_hs_ready", bus.inReady, 1);
        chk("post_hs_valid", bus.outValid, 0);
        chk("post_hs_busy", bus.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] k, p, e, p2, k2, e2;
        bit saw;
        n_tests = 0;
        n_fail  = 0;
        build_sbox();
        rst = 1'b1;
        bus.inValid  = 1'b0;
        bus.plainIn  = '0;
        bus.outReady = 1'b0;
        load_keys('0);
        step();
        step();
        chk("rst_inReady", bus.inReady, 1);
        chk("rst_rn", bus.roundNumber, 0);
        chk("rst_outValid", bus.outValid, 0);
        chk("rst_cipher", bus.cipherOut, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;

        // FIPS-197 Appendix B.
        load_keys(128'h2b7e151628aed2a6abf7158809cf4f3c);
        accept(128'h3243f6a8885a308d313198a2e0370734, 1'b0);
        finish_rounds(1'b0);
        drain(128'h3925841d02dc09fbdc118597196a0b32, 0);

        // FIPS-197 Appendix C.1 with 7 cycles of backpressure.
        load_keys(128'h000102030405060708090a0b0c0d0e0f);
        accept(128'h00112233445566778899aabbccddeeff, 1'b0);
        finish_rounds(1'b0);
        drain(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 7);

        // Random blocks with input/outReady noise during the rounds.
        for (int n = 0; n < 6; n++) begin
            k = rand128();
            p = rand128();
            e = ref_encrypt(k, p);
            load_keys(k);
            accept(p, 1'b0);
            finish_rounds(1'b1);
            bus.inValid = 1'b0;
            drain(e, $urandom_range(0, 4));
        end

        // Reset during round 5 discards the block.
        k = rand128();
        load_keys(k);
        accept(rand128(), 1'b0);
        repeat (4) step();
        chk("rn_round5", bus.roundNumber, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_outValid", bus.outValid, 0);
        chk("midrst_cipher", bus.cipherOut, 0);
        chk("midrst_inReady", bus.inReady, 1);
        chk("midrst_rn", bus.roundNumber, 0);
        saw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.outValid || bus.busy) saw = 1'b1;
        end
        chk("midrst_no_pulse", saw, 0);
        load_keys(128'h2b7e151628aed2a6abf7158809cf4f3c);
        accept(128'h3243f6a8885a308d313198a2e0370734, 1'b0);
        finish_rounds(1'b0);
        drain(128'h3925841d02dc09fbdc118597196a0b32, 2);

        // Reset in DONE beats a simultaneous handshake and new offer.
        k = rand128();
        load_keys(k);
        accept(rand128(), 1'b0);
        finish_rounds(1'b0);
        rst = 1'b1;
        bus.outReady = 1'b1;
        bus.inValid  = 1'b1;
        step();
        rst = 1'b0;
        bus.outReady = 1'b0;
        bus.inValid  = 1'b0;
        chk("donerst_outValid", bus.outValid, 0);
        chk("donerst_cipher", bus.cipherOut, 0);
        chk("donerst_busy", bus.busy, 0);

        // Reset beats an accept in IDLE.
        bus.inValid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.inValid = 1'b0;
        chk("idlerst_busy", bus.busy, 0);
        chk("idlerst_rn", bus.roundNumber, 0);

        // Two blocks with inValid held high throughout.
        k  = rand128();
        p  = rand128();
        e  = ref_encrypt(k, p);
        k2 = rand128();
        p2 = rand128();
        e2 = ref_encrypt(k2, p2);
        load_keys(k);
        accept(p, 1'b1);
        finish_rounds(1'b0);
        bus.plainIn = p2;
        drain(e, 1);
        load_keys(k2);
        accept(p2, 1'b0);
        chk("chain_rn1", bus.roundNumber, 1);
        finish_rounds(1'b0);
        drain(e2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
